// File: rtl/mem_ctrl_if.sv
// Command/response bus for mem_ctrl.
// Command channel: cmd_valid/cmd_ready handshake carrying cmd_we, cmd_addr,
// cmd_data and cmd_len (beats minus one).
// Response channel: rsp_valid/rsp_ready handshake carrying rsp_data and rsp_addr.
// master: the command issuer and response consumer. slave: the controller.
interface mem_ctrl_if #(
  parameter int unsigned N = 5
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_we;
  logic [N-1:0] cmd_addr;
  logic [N-1:0] cmd_data;
  logic [N-1:0] cmd_len;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic [N-1:0] rsp_addr;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Command sequencer in front of a 2**N-word register memory.
// Accepts single/burst read and write commands, walks consecutive addresses
// with wrap-around, and returns read data over a valid/ready response channel.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   bus (slave)      cmd_* command channel, rsp_* response channel
//   busy             high whenever the FSM is not IDLE
//   mem_we/mem_addr/mem_wdata  drive the memory
//   mem_rdata        registered read data from the memory
// Optional: define MEMCTRL_STATS_EN to add saturating wr_beats/rd_beats counters.
module mem_ctrl #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_ctrl_if.slave    bus,
  output logic         busy,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [15:0]  wr_beats,
  output logic [15:0]  rd_beats
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t       state;
  logic [N-1:0] cur_addr;
  logic [N-1:0] cnt;
  logic [N-1:0] next_addr;

  assign next_addr = cur_addr + N'(1);

  // Memory output is registered and held stable while mem_addr is held in RESP.
  assign bus.rsp_data = mem_rdata;

  // Sequencer FSM; mem_wdata doubles as the latched burst data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_addr  <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cur_addr      <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            cur_addr      <= bus.cmd_addr;
            cnt           <= bus.cmd_len;
            mem_addr      <= bus.cmd_addr;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (bus.cmd_we) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= bus.cmd_data;
            end else begin
              state <= READ;
            end
          end
        end

        WRITE: begin
          if (cnt == '0) begin
            state         <= IDLE;
            mem_we        <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            cnt      <= cnt - N'(1);
            cur_addr <= next_addr;
            mem_addr <= next_addr;
          end
        end

        // Memory captures mem[cur_addr] at the end of this cycle.
        READ: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_addr  <= cur_addr;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (cnt == '0) begin
              state         <= IDLE;
              bus.cmd_ready <= 1'b1;
              busy          <= 1'b0;
            end else begin
              state    <= READ;
              cnt      <= cnt - N'(1);
              cur_addr <= next_addr;
              mem_addr <= next_addr;
            end
          end
        end

        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          bus.rsp_valid <= 1'b0;
          mem_we        <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEMCTRL_STATS_EN
  // Saturating beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_beats <= '0;
      rd_beats <= '0;
    end else begin
      if (state == WRITE && wr_beats != 16'hFFFF) wr_beats <= wr_beats + 16'd1;
      if (bus.rsp_valid && bus.rsp_ready && rd_beats != 16'hFFFF) rd_beats <= rd_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural register memory, reference
// memory model, write/response scoreboards, a command table and hand sequences.
module tb_mem_ctrl;
  localparam int unsigned N = 5;

  typedef struct {
    logic [N-1:0] addr;
    logic [N-1:0] data;
  } beat_t;

  typedef struct {
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] data;
    logic [N-1:0] len;
    int           exp_cycles;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         busy;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata = '0;
`ifdef MEMCTRL_STATS_EN
  logic [15:0]  wr_beats;
  logic [15:0]  rd_beats;
`endif

  mem_ctrl_if #(.N(N)) bus ();

  mem_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEMCTRL_STATS_EN
    ,
    .wr_beats  (wr_beats),
    .rd_beats  (rd_beats)
`endif
  );

  always #5 clk = ~clk;

  // Register memory: write when we=1, otherwise register the addressed word.
  logic [N-1:0] mem_array [2**N] = '{default: '0};
  always @(posedge clk) begin
    if (mem_we) mem_array[mem_addr] <= mem_wdata;
    else        mem_rdata <= mem_array[mem_addr];
  end

  logic [N-1:0] ref_mem [2**N] = '{default: '0};
  beat_t        wq[$];
  beat_t        rq[$];
  int           checks = 0;
  int           errors = 0;
  int           exp_wr = 0;
  int           exp_rd = 0;
  vec_t         vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample the current cycle, score it, then advance one clock.
  task automatic tick();
    beat_t b;
    chk("we_rsp_excl", 32'(mem_we & bus.rsp_valid), 0);
    chk("ready_vs_busy", 32'(bus.cmd_ready), 32'(!busy));
    if (mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF);
      end else begin
        b = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(b.addr));
        chk("wr_data", 32'(mem_wdata), 32'(b.data));
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (rq.size() == 0) begin
        chk("unexpected_rsp_addr", 32'(bus.rsp_addr), 32'hFFFF);
      end else begin
        b = rq.pop_front();
        chk("rsp_addr", 32'(bus.rsp_addr), 32'(b.addr));
        chk("rsp_data", 32'(bus.rsp_data), 32'(b.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one command for a single accepting clock, recording expectations.
  task automatic issue(input logic we, input logic [N-1:0] addr, input logic [N-1:0] data,
                       input logic [N-1:0] len, input bit push);
    logic [N-1:0] a;
    chk("cmd_ready_before_issue", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    if (push) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + N'(i);
        if (we) begin
          ref_mem[a] = data;
          wq.push_back('{a, data});
        end else begin
          rq.push_back('{a, ref_mem[a]});
        end
      end
      if (we) exp_wr += int'(len) + 1;
      else    exp_rd += int'(len) + 1;
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Run until idle with both scoreboards empty, bounded.
  task automatic drain();
    int n = 0;
    while ((busy || wq.size() != 0 || rq.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < 300), 1);
    chk("wq_empty", 32'(wq.size()), 0);
    chk("rq_empty", 32'(rq.size()), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 5'd0,  5'h01, 5'd0,  1};
    vecs[1] = '{1'b1, 5'd28, 5'h1E, 5'd7,  8};
    vecs[2] = '{1'b0, 5'd28, 5'h00, 5'd7,  16};
    vecs[3] = '{1'b1, 5'd8,  5'h11, 5'd31, 32};
    vecs[4] = '{1'b0, 5'd8,  5'h00, 5'd31, 64};
    vecs[5] = '{1'b1, 5'd31, 5'h03, 5'd1,  2};
    vecs[6] = '{1'b0, 5'd30, 5'h00, 5'd2,  6};
    vecs[7] = '{1'b0, 5'd31, 5'h00, 5'd0,  2};

    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rsp_addr", 32'(bus.rsp_addr), 0);
    rst = 1'b0;
    tick();

    // Single write then single read at address 3.
    issue(1'b1, 5'd3, 5'h15, 5'd0, 1'b1);
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 3);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_we_done", 32'(mem_we), 0);
    chk("t1_ready_back", 32'(bus.cmd_ready), 1);
    issue(1'b0, 5'd3, 5'h00, 5'd0, 1'b1);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_data", 32'(bus.rsp_data), 32'h15);
    chk("t1_rsp_addr", 32'(bus.rsp_addr), 3);
    tick();
    chk("t1_idle", 32'(bus.cmd_ready), 1);

    // Write burst wrapping 30,31,0,1; cmd_ready low for exactly 4 cycles.
    issue(1'b1, 5'd30, 5'h0A, 5'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_we_beat", 32'(mem_we), 1);
      chk("t2_ready_low", 32'(bus.cmd_ready), 0);
      tick();
    end
    chk("t2_ready_back", 32'(bus.cmd_ready), 1);
    chk("t2_we_off", 32'(mem_we), 0);

    // Read burst 0..2, responses every second cycle.
    issue(1'b0, 5'd0, 5'h00, 5'd2, 1'b1);
    for (int j = 0; j < 7; j++) begin
      chk("t3_rsp_valid_pattern", 32'(bus.rsp_valid), 32'(j == 1 || j == 3 || j == 5));
      tick();
    end
    chk("t3_idle", 32'(bus.cmd_ready), 1);
    drain();

    // Response backpressure holds the response and consumes no beat.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 5'd31, 5'h00, 5'd1, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid_held", 32'(bus.rsp_valid), 1);
      chk("t4_data_held", 32'(bus.rsp_data), 32'(ref_mem[31]));
      chk("t4_addr_held", 32'(bus.rsp_addr), 31);
      chk("t4_no_we", 32'(mem_we), 0);
      tick();
    end
    chk("t4_rq_depth", 32'(rq.size()), 2);
    bus.rsp_ready = 1'b1;
    drain();

    // Command table with busy-duration expectations.
    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].len, 1'b1);
      n = 0;
      while (busy && n < 100) begin
        n++;
        tick();
      end
      chk($sformatf("vec%0d_busy_cycles", v), 32'(n), 32'(vecs[v].exp_cycles));
      drain();
    end

    // Commands presented while busy are ignored.
    issue(1'b1, 5'd5, 5'h07, 5'd1, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 5'd20;
    bus.cmd_data  = 5'h09;
    bus.cmd_len   = 5'd5;
    tick();
    tick();
    chk("t6_write_ended", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    issue(1'b0, 5'd5, 5'h00, 5'd0, 1'b1);
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    chk("t6_read_ended", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b0;
    drain();

`ifdef MEMCTRL_STATS_EN
    chk("stats_wr_beats", 32'(wr_beats), 32'(exp_wr));
    chk("stats_rd_beats", 32'(rd_beats), 32'(exp_rd));
`endif

    // Reset during beat 2 of a 4-beat write abandons the rest of the burst.
    issue(1'b1, 5'd10, 5'h1F, 5'd3, 1'b0);
    ref_mem[10] = 5'h1F;
    ref_mem[11] = 5'h1F;
    wq.push_back('{5'd10, 5'h1F});
    wq.push_back('{5'd11, 5'h1F});
    tick();
    tick();
    chk("t5_in_beat2", 32'(mem_addr), 12);
    rst = 1'b1;
    #1;
    chk("t5_rst_we", 32'(mem_we), 0);
    chk("t5_rst_ready", 32'(bus.cmd_ready), 1);
    chk("t5_rst_busy", 32'(busy), 0);
    exp_wr = 0;
    exp_rd = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick();
    chk("t5_wq_consumed", 32'(wq.size()), 0);
    issue(1'b0, 5'd12, 5'h00, 5'd1, 1'b1);
    drain();
`ifdef MEMCTRL_STATS_EN
    chk("stats_after_rst_wr", 32'(wr_beats), 32'(exp_wr));
    chk("stats_after_rst_rd", 32'(rd_beats), 32'(exp_rd));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
